// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// UART receiver with 16x oversampling, a configurable frame format and a
// small receive FIFO that is drained through a REQ/ACK handshake.
//
// Parameters:
//   CLKS_PER_TICK  clk cycles per oversample tick (>= 2); bit = 16 ticks
//   DATA_BITS      data bits per frame (5..9)
//   PARITY         0 = none, 1 = odd, 2 = even
//   STOP_BITS      stop bits checked (1 or 2)
//   FIFO_DEPTH     receive FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk       system clock, rising edge
//   clr       asynchronous active-low reset
//   RCV       serial line, idle high, asynchronous to clk
//   RCV_ACK   consumer accepts the head entry
//   RCV_REQ   FIFO not empty, head entry valid
//   RCV_Data  head entry data, LSB = first received bit
//   RCV_PERR  head entry parity error
//   RCV_FERR  head entry framing error
//   RCV_OVR   sticky overrun flag, cleared by the next pop
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLKS_PER_TICK = 27,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 RCV,
    input  logic                 RCV_ACK,
    output logic                 RCV_REQ,
    output logic [DATA_BITS-1:0] RCV_Data,
    output logic                 RCV_PERR,
    output logic                 RCV_FERR,
    output logic                 RCV_OVR
);

    localparam int TW = $clog2(CLKS_PER_TICK);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_BITS + 2;

    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [1:0]           sync_q, sync_d;
    logic                 rx_s;
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [3:0]           os_cnt_q, os_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovr_q, ovr_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];

    logic                 tick;
    logic                 bit_sample;
    logic                 frame_done;
    logic                 fifo_full;
    logic                 wr_en;
    logic                 pop;
    logic [EW-1:0]        wr_data;
    logic [EW-1:0]        head;

    // Synchroniser shifts toward sync_q[1]; preset to idle-high by reset.
    assign sync_d = {sync_q[0], RCV};
    assign rx_s   = sync_q[1];

    // The tick counter only runs while a frame is being sampled, so entry to
    // START always begins from zero.
    assign tick       = (tick_cnt_q == TICK_LAST);
    assign bit_sample = tick && (os_cnt_q == 4'd15);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = '0;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;

        if (state_q != S_IDLE && state_q != S_WAIT_IDLE) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
            if (tick) begin
                os_cnt_d = os_cnt_q + 4'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                os_cnt_d  = '0;
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Eighth tick lands in the middle of the start bit.
                if (tick && os_cnt_q == 4'd7) begin
                    os_cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (bit_sample) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_sample) begin
                    perr_d  = (PARITY == 1) ? ~(^shift_q ^ rx_s) : (^shift_q ^ rx_s);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_sample) begin
                    ferr_d = ferr_q | ~rx_s;
                    if (bit_cnt_q == STOP_LAST) begin
                        frame_done = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The entry is written in the cycle of the last stop sample, so the
    // framing bit folds in the sample being taken right now.
    assign wr_data = {ferr_q | ~rx_s, perr_q, shift_q};

    // Fullness comes from the registered count: a same-cycle pop does not
    // make room for the incoming frame.
    assign fifo_full = (count_q == DEPTH_C);
    assign RCV_REQ   = (count_q != '0);
    assign pop       = RCV_REQ & RCV_ACK;
    assign wr_en     = frame_done & ~fifo_full;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end
        // A new overrun wins over the clearing pop.
        ovr_d = ovr_q;
        if (frame_done && fifo_full) begin
            ovr_d = 1'b1;
        end else if (pop) begin
            ovr_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q     <= 2'b11;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
        end
    end

    // NOTE: storage is not reset; entries are only observed while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign RCV_Data = head[DATA_BITS-1:0];
    assign RCV_PERR = head[DATA_BITS];
    assign RCV_FERR = head[DATA_BITS+1];
    assign RCV_OVR  = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Two receivers share clock and reset: dut8 is 8N1, dut7 is 7E1. Serial
// frames are driven bit by bit. A queue-style model per receiver holds the
// entries the FIFO must contain; each frame's entry becomes due at the clock
// edge of its last (mid-bit) stop sample, and a compare thread checks the
// outputs against the model on every falling edge. Directed literal checks
// pin the model's view at key points.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int CPT      = 4;
    localparam int BIT_CLKS = 16 * CPT;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       rcv8, ack8, rcv7, ack7;
    logic       d8_req, d8_perr, d8_ferr, d8_ovr;
    logic [7:0] d8_data;
    logic       d7_req, d7_perr, d7_ferr, d7_ovr;
    logic [6:0] d7_data;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_TICK(CPT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut8 (
        .clk(clk), .clr(clr), .RCV(rcv8), .RCV_ACK(ack8), .RCV_REQ(d8_req),
        .RCV_Data(d8_data), .RCV_PERR(d8_perr), .RCV_FERR(d8_ferr), .RCV_OVR(d8_ovr)
    );

    uart_rx_fifo #(
        .CLKS_PER_TICK(CPT), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut7 (
        .clk(clk), .clr(clr), .RCV(rcv7), .RCV_ACK(ack7), .RCV_REQ(d7_req),
        .RCV_Data(d7_data), .RCV_PERR(d7_perr), .RCV_FERR(d7_ferr), .RCV_OVR(d7_ovr)
    );

    int checks = 0;
    int errors = 0;

    // Edge bookkeeping: cyc counts rising edges, ack_edge holds the ACK
    // value each receiver saw at the latest edge.
    int         cyc = 0;
    logic [1:0] ack_edge = 2'b00;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        ack_edge <= {ack7, ack8};
    end

    // Model: entry = {ferr, perr, data[8:0]}.
    logic [10:0] mq [2][64];
    int          mhead [2];
    int          mtail [2];
    logic        movr [2];
    logic        pend_v [2];
    int          pend_due [2];
    logic [10:0] pend_val [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_flush();
        for (int id = 0; id < 2; id++) begin
            mhead[id]  = 0;
            mtail[id]  = 0;
            movr[id]   = 1'b0;
            pend_v[id] = 1'b0;
        end
    endtask

    // Apply what the latest rising edge did, then compare.
    task automatic model_step(input int id);
        int          sz;
        logic        do_pop, ovf;
        logic        a_req, a_ovr, a_perr, a_ferr;
        logic [8:0]  a_data;
        logic [10:0] e;
        sz     = mtail[id] - mhead[id];
        do_pop = ack_edge[id] && (sz > 0);
        ovf    = 1'b0;
        if (pend_v[id] && pend_due[id] == cyc) begin
            pend_v[id] = 1'b0;
            if (sz >= DEPTH) begin
                ovf = 1'b1;
            end else begin
                mq[id][mtail[id] % 64] = pend_val[id];
                mtail[id]++;
            end
        end
        if (do_pop) mhead[id]++;
        if (ovf) movr[id] = 1'b1;
        else if (do_pop) movr[id] = 1'b0;

        if (id == 0) begin
            a_req = d8_req; a_ovr = d8_ovr; a_perr = d8_perr; a_ferr = d8_ferr;
            a_data = {1'b0, d8_data};
        end else begin
            a_req = d7_req; a_ovr = d7_ovr; a_perr = d7_perr; a_ferr = d7_ferr;
            a_data = {2'b00, d7_data};
        end
        check($sformatf("dut%0d_req", id), 32'(a_req), 32'(mtail[id] != mhead[id]));
        check($sformatf("dut%0d_ovr", id), 32'(a_ovr), 32'(movr[id]));
        if (mtail[id] != mhead[id]) begin
            e = mq[id][mhead[id] % 64];
            check($sformatf("dut%0d_data", id), 32'(a_data), 32'(e[8:0]));
            check($sformatf("dut%0d_perr", id), 32'(a_perr), 32'(e[9]));
            check($sformatf("dut%0d_ferr", id), 32'(a_ferr), 32'(e[10]));
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rcv(input int id, input logic v);
        if (id == 0) rcv8 = v;
        else         rcv7 = v;
    endtask

    // Start edge driven after edge n reaches rx_s two edges later and is
    // acted on at edge n+3; the k-th tick is consumed at edge n+3+CPT*k and
    // the last stop sample falls on tick 8 + 16*(bits after the start bit).
    task automatic schedule(input int id, input int frame_bits, input logic [10:0] e);
        pend_due[id] = cyc + 3 + CPT * (8 + 16 * frame_bits);
        pend_val[id] = e;
        pend_v[id]   = 1'b1;
    endtask

    task automatic send_frame(input int id, input logic [8:0] data, input int nbits,
                              input int par_mode, input logic par_bit, input logic stop_bit);
        logic perr;
        int   pb;
        pb   = (par_mode != 0) ? 1 : 0;
        perr = 1'b0;
        if (par_mode == 1) perr = ~(^data ^ par_bit);
        if (par_mode == 2) perr = ^data ^ par_bit;
        schedule(id, nbits + pb + 1, {~stop_bit, perr, data});
        set_rcv(id, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < nbits; i++) begin
            set_rcv(id, data[i]);
            wait_clks(BIT_CLKS);
        end
        if (pb == 1) begin
            set_rcv(id, par_bit);
            wait_clks(BIT_CLKS);
        end
        set_rcv(id, stop_bit);
        wait_clks(BIT_CLKS);
        set_rcv(id, 1'b1);
    endtask

    task automatic pop8();
        ack8 = 1'b1;
        wait_clks(1);
        ack8 = 1'b0;
    endtask

    task automatic pop7();
        ack7 = 1'b1;
        wait_clks(1);
        ack7 = 1'b0;
    endtask

    initial begin
        clr  = 1'b0;
        rcv8 = 1'b1;
        rcv7 = 1'b1;
        ack8 = 1'b0;
        ack7 = 1'b0;
        model_flush();

        fork
            forever begin
                @(negedge clk);
                if (!clr) begin
                    model_flush();
                end else begin
                    model_step(0);
                    model_step(1);
                end
            end
        join_none

        // Reset state.
        wait_clks(5);
        check("rst_req8", 32'(d8_req), 32'd0);
        check("rst_ovr8", 32'(d8_ovr), 32'd0);
        check("rst_req7", 32'(d7_req), 32'd0);
        check("rst_ovr7", 32'(d7_ovr), 32'd0);
        clr = 1'b1;
        wait_clks(5);

        // Basic frame, then a single ACK pulse.
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1);
        wait_clks(5);
        check("basic_req", 32'(d8_req), 32'd1);
        check("basic_data", 32'(d8_data), 32'h0A5);
        check("basic_perr", 32'(d8_perr), 32'd0);
        check("basic_ferr", 32'(d8_ferr), 32'd0);
        pop8();
        check("basic_pop_req", 32'(d8_req), 32'd0);

        // Glitch shorter than half a bit.
        set_rcv(0, 1'b0);
        wait_clks(20);
        set_rcv(0, 1'b1);
        wait_clks(100);
        check("glitch_req", 32'(d8_req), 32'd0);

        // Framing error.
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b0);
        wait_clks(10);
        check("ferr_req", 32'(d8_req), 32'd1);
        check("ferr_data", 32'(d8_data), 32'h03C);
        check("ferr_flag", 32'(d8_ferr), 32'd1);
        pop8();

        // Break: line held low for 1000 clocks gives one all-zero entry.
        schedule(0, 9, {1'b1, 1'b0, 9'h000});
        set_rcv(0, 1'b0);
        wait_clks(1000);
        set_rcv(0, 1'b1);
        wait_clks(20);
        check("brk_req", 32'(d8_req), 32'd1);
        check("brk_data", 32'(d8_data), 32'h000);
        check("brk_ferr", 32'(d8_ferr), 32'd1);
        pop8();
        check("brk_single", 32'(d8_req), 32'd0);
        send_frame(0, 9'h066, 8, 0, 1'b0, 1'b1);
        wait_clks(5);
        check("after_brk_data", 32'(d8_data), 32'h066);
        check("after_brk_ferr", 32'(d8_ferr), 32'd0);
        pop8();

        // Overrun: five back-to-back frames, no ACK.
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 9'(i), 8, 0, 1'b0, 1'b1);
        end
        wait_clks(5);
        check("ovr_flag", 32'(d8_ovr), 32'd1);
        check("ovr_head", 32'(d8_data), 32'h01);

        // Drain with ACK held high: one entry per cycle.
        ack8 = 1'b1;
        wait_clks(1);
        check("drain_1", 32'(d8_data), 32'h02);
        check("drain_ovr_clr", 32'(d8_ovr), 32'd0);
        wait_clks(1);
        check("drain_2", 32'(d8_data), 32'h03);
        wait_clks(1);
        check("drain_3", 32'(d8_data), 32'h04);
        wait_clks(1);
        check("drain_empty", 32'(d8_req), 32'd0);
        ack8 = 1'b0;
        wait_clks(5);

        // Reset in the middle of the 4th data bit of 0xFF.
        send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1);
        wait_clks(5);
        set_rcv(0, 1'b0);
        wait_clks(BIT_CLKS);
        set_rcv(0, 1'b1);
        wait_clks(BIT_CLKS * 3 + BIT_CLKS / 2);
        clr = 1'b0;
        wait_clks(3);
        check("mid_rst_req", 32'(d8_req), 32'd0);
        clr = 1'b1;
        wait_clks(BIT_CLKS * 6);
        check("post_rst_req", 32'(d8_req), 32'd0);
        send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1);
        wait_clks(5);
        check("post_rst_data", 32'(d8_data), 32'h05A);
        check("post_rst_ovr", 32'(d8_ovr), 32'd0);
        pop8();
        check("post_rst_one", 32'(d8_req), 32'd0);

        // 7E1 receiver: 0x41 has an even number of ones.
        send_frame(1, 9'h041, 7, 2, 1'b0, 1'b1);
        wait_clks(5);
        check("par_ok_data", 32'(d7_data), 32'h41);
        check("par_ok_perr", 32'(d7_perr), 32'd0);
        pop7();
        send_frame(1, 9'h041, 7, 2, 1'b1, 1'b1);
        wait_clks(5);
        check("par_bad_data", 32'(d7_data), 32'h41);
        check("par_bad_perr", 32'(d7_perr), 32'd1);
        pop7();
        wait_clks(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
